// File: rtl/bubble_sort_ctrl_pkg.sv
// Shared sort definitions: ALU opcodes and the controller's state encoding.
package sort_pkg;

    localparam logic [1:0] ADD     = 2'b00;
    localparam logic [1:0] SUB     = 2'b01;
    localparam logic [1:0] ADD_1   = 2'b10;
    localparam logic [1:0] COMPARE = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        CMP,
        SW0,
        SW1,
        ADV,
        DONE
    } state_e;

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Start/done handshake plus RAM and ALU bus of the bubble-sort controller.
interface bubble_sort_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
);

    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [1:0]            alu_sel;
    logic [DATA_WIDTH-1:0] alu_in_1;
    logic [DATA_WIDTH-1:0] alu_in_2;
    logic                  alu_lt;
    logic                  alu_eq;
    logic                  alu_gt;
    logic [CNT_WIDTH-1:0]  swap_count;
    logic [CNT_WIDTH-1:0]  pass_count;

    modport master (
        input  start, len, mem_rd_data, alu_lt, alu_eq, alu_gt,
        output busy, done, mem_addr, mem_wr_en, mem_wr_data,
               alu_sel, alu_in_1, alu_in_2, swap_count, pass_count
    );

    modport slave (
        output start, len, mem_rd_data, alu_lt, alu_eq, alu_gt,
        input  busy, done, mem_addr, mem_wr_en, mem_wr_data,
               alu_sel, alu_in_1, alu_in_2, swap_count, pass_count
    );

endinterface

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencer: reads pairs from RAM, compares them on the ALU,
// writes back swapped pairs and repeats passes until a pass makes no swap.
module bubble_sort_ctrl
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    bubble_sort_ctrl_if.master bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_V   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]   limit_q, limit_d;
    logic                  swapped_q, swapped_d;
    logic [DATA_WIDTH-1:0] a_reg_q, a_reg_d;
    logic [DATA_WIDTH-1:0] b_reg_q, b_reg_d;
    logic [CNT_WIDTH-1:0]  swap_cnt_q, swap_cnt_d;
    logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;

    logic [ADDR_WIDTH:0]   len_sat;
    logic [ADDR_WIDTH:0]   idx_p1;
    logic                  unused_flags;

    // Only alu_gt decides a swap; lt/eq are part of the bus but not needed.
    assign unused_flags = ^{bus.alu_lt, bus.alu_eq};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            limit_q    <= '0;
            swapped_q  <= 1'b0;
            a_reg_q    <= '0;
            b_reg_q    <= '0;
            swap_cnt_q <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            limit_q    <= limit_d;
            swapped_q  <= swapped_d;
            a_reg_q    <= a_reg_d;
            b_reg_q    <= b_reg_d;
            swap_cnt_q <= swap_cnt_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        limit_d         = limit_q;
        swapped_d       = swapped_q;
        a_reg_d         = a_reg_q;
        b_reg_d         = b_reg_q;
        swap_cnt_d      = swap_cnt_q;
        pass_cnt_d      = pass_cnt_q;
        bus.mem_addr    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = '0;
        bus.alu_sel     = ADD;

        len_sat = (bus.len > DEPTH_V) ? DEPTH_V : bus.len;
        idx_p1  = idx_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    swap_cnt_d = '0;
                    if (len_sat[ADDR_WIDTH:1] == '0) begin
                        pass_cnt_d = '0;
                        state_d    = DONE;
                    end else begin
                        idx_d      = '0;
                        limit_d    = len_sat - 1'b1;
                        swapped_d  = 1'b0;
                        pass_cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        state_d    = RD0;
                    end
                end
            end
            RD0: begin
                bus.mem_addr = idx_q[ADDR_WIDTH-1:0];
                state_d      = RD1;
            end
            RD1: begin
                bus.mem_addr = idx_p1[ADDR_WIDTH-1:0];
                a_reg_d      = bus.mem_rd_data;
                state_d      = RD2;
            end
            RD2: begin
                b_reg_d = bus.mem_rd_data;
                state_d = CMP;
            end
            CMP: begin
                bus.alu_sel = COMPARE;
                state_d     = bus.alu_gt ? SW0 : ADV;
            end
            SW0: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = idx_q[ADDR_WIDTH-1:0];
                bus.mem_wr_data = b_reg_q;
                state_d         = SW1;
            end
            SW1: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_addr    = idx_p1[ADDR_WIDTH-1:0];
                bus.mem_wr_data = a_reg_q;
                swapped_d       = 1'b1;
                swap_cnt_d      = (&swap_cnt_q) ? swap_cnt_q : swap_cnt_q + 1'b1;
                state_d         = ADV;
            end
            ADV: begin
                if (idx_p1 == limit_q) begin
                    if (!swapped_q || limit_q == ONE_V) begin
                        state_d = DONE;
                    end else begin
                        limit_d    = limit_q - 1'b1;
                        idx_d      = '0;
                        swapped_d  = 1'b0;
                        pass_cnt_d = (&pass_cnt_q) ? pass_cnt_q : pass_cnt_q + 1'b1;
                        state_d    = RD0;
                    end
                end else begin
                    idx_d   = idx_p1;
                    state_d = RD0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
    assign bus.done       = (state_q == DONE);
    assign bus.alu_in_1   = a_reg_q;
    assign bus.alu_in_2   = b_reg_q;
    assign bus.swap_count = swap_cnt_q;
    assign bus.pass_count = pass_cnt_q;

endmodule
